uart_rx_cfg: RTL

//  Parametrised UART receiver. Successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Purpose: parametrised UART receiver with a 2-FF input synchroniser, mid-bit
//          sampling, false-start rejection, optional parity and 1/2 stop bits.
// Latency: frame appears in the holding register (valid=1) 1 clk after the
//          edge that takes the final stop-bit sample; rx to rx_s is 2 clk.
// Backpressure: a single holding register. A frame that completes while the
//          register is full and not being drained is dropped, with a 1-cycle overrun pulse.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   enable            gates recognition of new start bits only
//   rx                async serial line, idles high
//   data_out/valid    received payload (right-aligned) and holding-full flag
//   ready             consumer accept, taken on valid && ready at a rising edge
//   frame_err         held frame had a 0 in a stop bit (qualified by valid)
//   parity_err        held frame failed the parity check (qualified by valid)
//   overrun           1-cycle pulse when a completed frame is dropped
//   busy              receiver FSM is not idle
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  // XOR of payload and parity bit must equal this for a good frame.
  localparam logic            PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [3:0]             bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0]   shreg, shreg_nx;
  logic                   ferr_acc, ferr_acc_nx;
  logic                   perr_acc, perr_acc_nx;
  logic                   done, done_nx;
  logic                   rx_meta, rx_s;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      ferr_acc <= ferr_acc_nx;
      perr_acc <= perr_acc_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CW'(1);
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    ferr_acc_nx = ferr_acc;
    perr_acc_nx = perr_acc;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable && !rx_s) begin
          state_nx    = START;
          bit_cnt_nx  = '0;
          ferr_acc_nx = 1'b0;
          perr_acc_nx = 1'b0;
        end
      end
      START: begin
        // Mid start bit: a high line means a glitch, not a frame.
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nx = '0;
            state_nx   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end
      PAR: begin
        if (cnt == FULL_M1) begin
          cnt_nx      = '0;
          perr_acc_nx = ((^shreg) ^ rx_s) != PAR_ODD;
          state_nx    = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx = '0;
          if (!rx_s) ferr_acc_nx = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nx = '0;
            state_nx   = IDLE;
            done_nx    = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Holding register. done is a registered pulse, so shreg and the error
  // accumulators are already final when it is seen; a new start bit can only
  // clear the accumulators at the end of this same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data_out   <= shreg;
          frame_err  <= ferr_acc;
          parity_err <= perr_acc;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
